// File: rtl/io_port_responder.sv
// ============================================================================
// io_port_responder
// ----------------------------------------------------------------------------
// Device-side responder for the Controller's IN/OUT port traffic.
//
//   OUT path: core OUT words are buffered in a TX FIFO. The head of the FIFO is
//   offered to an external valid/ready sink with first-word fall-through.
//
//   IN path: an external valid/ready source fills an RX FIFO. Core IN requests
//   are answered through a small IDLE/WAIT/ACK state machine. The core holds
//   core_in_req high until it sees the one-cycle core_in_ack pulse.
//
// Parameters
//   DATA_W  port word width
//   DEPTH   entries per FIFO (power of two, >= 2)
//   ADDR_W  log2(DEPTH), pointer width
//
// Ports
//   clock          in   system clock, rising edge
//   reset_n        in   asynchronous active-low reset
//   core_out_req   in   one-cycle pulse: push core_out_data into TX FIFO
//   core_out_data  in   OUT word
//   core_out_full  out  TX FIFO full
//   core_in_req    in   IN request, held by the core until acknowledged
//   core_in_data   out  IN word, valid while core_in_ack=1, held until next pop
//   core_in_ack    out  one-cycle pulse marking core_in_data valid
//   ext_tx_data    out  TX FIFO head
//   ext_tx_valid   out  TX FIFO not empty
//   ext_tx_ready   in   sink accepts head when valid & ready
//   ext_rx_data    in   incoming word
//   ext_rx_valid   in   source offers ext_rx_data
//   ext_rx_ready   out  RX FIFO not full
//
// Optional feature, compile-time macro IO_ERR_FLAGS_EN:
//   err_overflow   out  sticky: an OUT push arrived while the TX FIFO was full
//   err_underflow  out  sticky: an IN request had to wait on an empty RX FIFO
//   Both flags are cleared only by reset. Without the macro the ports and
//   their logic are absent and a dropped push is silent.
// ============================================================================
module io_port_responder #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              core_out_req,
    input  logic [DATA_W-1:0] core_out_data,
    output logic              core_out_full,
    input  logic              core_in_req,
    output logic [DATA_W-1:0] core_in_data,
    output logic              core_in_ack,
    output logic [DATA_W-1:0] ext_tx_data,
    output logic              ext_tx_valid,
    input  logic              ext_tx_ready,
    input  logic [DATA_W-1:0] ext_rx_data,
    input  logic              ext_rx_valid,
    output logic              ext_rx_ready
`ifdef IO_ERR_FLAGS_EN
    ,
    output logic              err_overflow,
    output logic              err_underflow
`endif
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]   CNT_ZERO = {(ADDR_W+1){1'b0}};
    localparam logic [ADDR_W-1:0] PTR_ONE  = (ADDR_W)'(1);
    localparam logic [ADDR_W-1:0] PTR_ZERO = {ADDR_W{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_ACK  = 2'b10
    } in_state_t;

    // ------------------------------------------------------------------------
    // TX FIFO state
    // ------------------------------------------------------------------------
    logic [DATA_W-1:0] tx_mem_r [DEPTH];
    logic [ADDR_W-1:0] tx_wr_ptr_r;
    logic [ADDR_W-1:0] tx_rd_ptr_r;
    logic [ADDR_W:0]   tx_count_r;
    logic              tx_full_s;
    logic              tx_empty_s;
    logic              tx_push_s;
    logic              tx_pop_s;

    // ------------------------------------------------------------------------
    // RX FIFO state
    // ------------------------------------------------------------------------
    logic [DATA_W-1:0] rx_mem_r [DEPTH];
    logic [ADDR_W-1:0] rx_wr_ptr_r;
    logic [ADDR_W-1:0] rx_rd_ptr_r;
    logic [ADDR_W:0]   rx_count_r;
    logic              rx_full_s;
    logic              rx_empty_s;
    logic              rx_push_s;
    logic              rx_pop_s;

    // ------------------------------------------------------------------------
    // IN handshake state
    // ------------------------------------------------------------------------
    in_state_t         state_r;
    in_state_t         state_nxt_s;
    logic [DATA_W-1:0] core_in_data_r;

    // ------------------------------------------------------------------------
    // FIFO status and handshake qualifiers
    // ------------------------------------------------------------------------
    assign tx_full_s  = (tx_count_r == CNT_FULL);
    assign tx_empty_s = (tx_count_r == CNT_ZERO);
    assign rx_full_s  = (rx_count_r == CNT_FULL);
    assign rx_empty_s = (rx_count_r == CNT_ZERO);

    // Full is taken from the registered count, so a push offered while full is
    // dropped even when the sink pops in the same cycle.
    assign tx_push_s  = core_out_req & ~tx_full_s;
    assign tx_pop_s   = ~tx_empty_s & ext_tx_ready;
    assign rx_push_s  = ext_rx_valid & ~rx_full_s;

    assign core_out_full = tx_full_s;
    assign ext_tx_valid  = ~tx_empty_s;
    assign ext_tx_data   = tx_mem_r[tx_rd_ptr_r];
    assign ext_rx_ready  = ~rx_full_s;
    assign core_in_data  = core_in_data_r;
    assign core_in_ack   = (state_r == ST_ACK);

    // TX storage write port; contents deliberately survive reset.
    always_ff @(posedge clock) begin
        if (tx_push_s) begin
            tx_mem_r[tx_wr_ptr_r] <= core_out_data;
        end
    end

    // TX pointers: each wraps modulo DEPTH by natural overflow.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tx_wr_ptr_r <= PTR_ZERO;
            tx_rd_ptr_r <= PTR_ZERO;
        end else begin
            if (tx_push_s) begin
                tx_wr_ptr_r <= tx_wr_ptr_r + PTR_ONE;
            end else begin
                tx_wr_ptr_r <= tx_wr_ptr_r;
            end
            if (tx_pop_s) begin
                tx_rd_ptr_r <= tx_rd_ptr_r + PTR_ONE;
            end else begin
                tx_rd_ptr_r <= tx_rd_ptr_r;
            end
        end
    end

    // TX occupancy; simultaneous push and pop leave it unchanged.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tx_count_r <= CNT_ZERO;
        end else begin
            case ({tx_push_s, tx_pop_s})
                2'b10:   tx_count_r <= tx_count_r + CNT_ONE;
                2'b01:   tx_count_r <= tx_count_r - CNT_ONE;
                default: tx_count_r <= tx_count_r;
            endcase
        end
    end

    // RX storage write port; contents deliberately survive reset.
    always_ff @(posedge clock) begin
        if (rx_push_s) begin
            rx_mem_r[rx_wr_ptr_r] <= ext_rx_data;
        end
    end

    // RX pointers: each wraps modulo DEPTH by natural overflow.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_wr_ptr_r <= PTR_ZERO;
            rx_rd_ptr_r <= PTR_ZERO;
        end else begin
            if (rx_push_s) begin
                rx_wr_ptr_r <= rx_wr_ptr_r + PTR_ONE;
            end else begin
                rx_wr_ptr_r <= rx_wr_ptr_r;
            end
            if (rx_pop_s) begin
                rx_rd_ptr_r <= rx_rd_ptr_r + PTR_ONE;
            end else begin
                rx_rd_ptr_r <= rx_rd_ptr_r;
            end
        end
    end

    // RX occupancy; simultaneous push and pop leave it unchanged.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_count_r <= CNT_ZERO;
        end else begin
            case ({rx_push_s, rx_pop_s})
                2'b10:   rx_count_r <= rx_count_r + CNT_ONE;
                2'b01:   rx_count_r <= rx_count_r - CNT_ONE;
                default: rx_count_r <= rx_count_r;
            endcase
        end
    end

    // IN handshake state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // IN handshake next state and RX pop decision. The pop happens on the
    // transition into ACK, so the word is already registered during the ack.
    // core_in_req is not looked at in ACK, so a request held through the ack
    // cycle is only seen again from IDLE.
    always_comb begin
        state_nxt_s = state_r;
        rx_pop_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (core_in_req) begin
                    if (!rx_empty_s) begin
                        rx_pop_s    = 1'b1;
                        state_nxt_s = ST_ACK;
                    end else begin
                        state_nxt_s = ST_WAIT;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!core_in_req) begin
                    state_nxt_s = ST_IDLE;
                end else if (!rx_empty_s) begin
                    rx_pop_s    = 1'b1;
                    state_nxt_s = ST_ACK;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_ACK: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                // Unused encoding: recover to a safe idle state.
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // IN data register: captures the RX head on a pop and holds it otherwise.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            core_in_data_r <= {DATA_W{1'b0}};
        end else if (rx_pop_s) begin
            core_in_data_r <= rx_mem_r[rx_rd_ptr_r];
        end else begin
            core_in_data_r <= core_in_data_r;
        end
    end

`ifdef IO_ERR_FLAGS_EN
    logic err_overflow_r;
    logic err_underflow_r;
    logic overflow_evt_s;
    logic underflow_evt_s;

    // Overflow is an OUT pulse against the registered full flag; underflow is
    // each entry into WAIT from IDLE (a request finding nothing to read).
    assign overflow_evt_s  = core_out_req & tx_full_s;
    assign underflow_evt_s = (state_r == ST_IDLE) && (state_nxt_s == ST_WAIT);

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            err_overflow_r  <= 1'b0;
            err_underflow_r <= 1'b0;
        end else begin
            err_overflow_r  <= err_overflow_r  | overflow_evt_s;
            err_underflow_r <= err_underflow_r | underflow_evt_s;
        end
    end

    assign err_overflow  = err_overflow_r;
    assign err_underflow = err_underflow_r;
`endif

endmodule

// File: tb/tb_io_port_responder.sv
// ============================================================================
// tb_io_port_responder
// ----------------------------------------------------------------------------
// Self-checking bench for io_port_responder. A queue-based reference model
// (TX queue, RX queue, pending-ack flag) advances once per clock from the
// inputs driven that cycle; directed scenario tasks check against constants
// and a randomized phase checks every output against the model each cycle.
// Inputs are driven and outputs sampled on the falling clock edge.
// ============================================================================
module tb_io_port_responder;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;

    logic              clock;
    logic              reset_n;
    logic              core_out_req;
    logic [DATA_W-1:0] core_out_data;
    logic              core_out_full;
    logic              core_in_req;
    logic [DATA_W-1:0] core_in_data;
    logic              core_in_ack;
    logic [DATA_W-1:0] ext_tx_data;
    logic              ext_tx_valid;
    logic              ext_tx_ready;
    logic [DATA_W-1:0] ext_rx_data;
    logic              ext_rx_valid;
    logic              ext_rx_ready;
`ifdef IO_ERR_FLAGS_EN
    logic              err_overflow;
    logic              err_underflow;
`endif

    int pass_cnt  = 0;
    int check_cnt = 0;

    // Reference model state
    logic [DATA_W-1:0] tx_q [$];
    logic [DATA_W-1:0] rx_q [$];
    logic              m_ack;
    logic              m_wait;
    logic [DATA_W-1:0] m_in_data;
`ifdef IO_ERR_FLAGS_EN
    logic              m_ovf;
    logic              m_unf;
`endif

    io_port_responder #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .core_out_req  (core_out_req),
        .core_out_data (core_out_data),
        .core_out_full (core_out_full),
        .core_in_req   (core_in_req),
        .core_in_data  (core_in_data),
        .core_in_ack   (core_in_ack),
        .ext_tx_data   (ext_tx_data),
        .ext_tx_valid  (ext_tx_valid),
        .ext_tx_ready  (ext_tx_ready),
        .ext_rx_data   (ext_rx_data),
        .ext_rx_valid  (ext_rx_valid),
        .ext_rx_ready  (ext_rx_ready)
`ifdef IO_ERR_FLAGS_EN
        ,
        .err_overflow  (err_overflow),
        .err_underflow (err_underflow)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic void model_reset();
        tx_q.delete();
        rx_q.delete();
        m_ack     = 1'b0;
        m_wait    = 1'b0;
        m_in_data = 16'h0000;
`ifdef IO_ERR_FLAGS_EN
        m_ovf     = 1'b0;
        m_unf     = 1'b0;
`endif
    endfunction

    // Advance the model by one clock using the currently driven inputs.
    function automatic void model_update();
        bit tx_full_pre;
        bit rx_full_pre;
        bit rx_has_word;
        tx_full_pre = (tx_q.size() == DEPTH);
        rx_full_pre = (rx_q.size() == DEPTH);
        rx_has_word = (rx_q.size() != 0);
        // OUT side: fullness judged before the sink takes a word this cycle
        if (tx_q.size() != 0 && ext_tx_ready) void'(tx_q.pop_front());
        if (core_out_req && !tx_full_pre) tx_q.push_back(core_out_data);
`ifdef IO_ERR_FLAGS_EN
        if (core_out_req && tx_full_pre) m_ovf = 1'b1;
`endif
        // IN side: an ack cycle ignores the request
        if (m_ack) begin
            m_ack  = 1'b0;
            m_wait = 1'b0;
        end else if (core_in_req) begin
            if (rx_has_word) begin
                m_in_data = rx_q.pop_front();
                m_ack     = 1'b1;
                m_wait    = 1'b0;
            end else begin
`ifdef IO_ERR_FLAGS_EN
                if (!m_wait) m_unf = 1'b1;
`endif
                m_wait = 1'b1;
            end
        end else begin
            m_wait = 1'b0;
        end
        if (ext_rx_valid && !rx_full_pre) rx_q.push_back(ext_rx_data);
    endfunction

    task automatic tick();
        model_update();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic idle_inputs();
        core_out_req  = 1'b0;
        core_out_data = 16'h0000;
        core_in_req   = 1'b0;
        ext_tx_ready  = 1'b0;
        ext_rx_data   = 16'h0000;
        ext_rx_valid  = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        idle_inputs();
        model_reset();
        @(negedge clock);
        check_cnt++;
        if (core_out_full !== 1'b0) $display("FAIL reset_full got=%b exp=0", core_out_full);
        else pass_cnt++;
        check_cnt++;
        if (ext_tx_valid !== 1'b0) $display("FAIL reset_tx_valid got=%b exp=0", ext_tx_valid);
        else pass_cnt++;
        check_cnt++;
        if (ext_rx_ready !== 1'b1) $display("FAIL reset_rx_ready got=%b exp=1", ext_rx_ready);
        else pass_cnt++;
        check_cnt++;
        if (core_in_ack !== 1'b0) $display("FAIL reset_ack got=%b exp=0", core_in_ack);
        else pass_cnt++;
        check_cnt++;
        if (core_in_data !== 16'h0000) $display("FAIL reset_in_data got=%h exp=0000", core_in_data);
        else pass_cnt++;
`ifdef IO_ERR_FLAGS_EN
        check_cnt++;
        if ({err_overflow, err_underflow} !== 2'b00)
            $display("FAIL reset_err_flags got=%b%b exp=00", err_overflow, err_underflow);
        else pass_cnt++;
`endif
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_tx_basic();
        ext_tx_ready  = 1'b1;
        core_out_req  = 1'b1;
        core_out_data = 16'h1234;
        tick();
        check_cnt++;
        if (ext_tx_valid !== 1'b1 || ext_tx_data !== 16'h1234)
            $display("FAIL tx_first got=%b/%h exp=1/1234", ext_tx_valid, ext_tx_data);
        else pass_cnt++;
        core_out_data = 16'hBEEF;
        tick();
        check_cnt++;
        if (ext_tx_valid !== 1'b1 || ext_tx_data !== 16'hBEEF)
            $display("FAIL tx_second got=%b/%h exp=1/beef", ext_tx_valid, ext_tx_data);
        else pass_cnt++;
        core_out_req = 1'b0;
        tick();
        check_cnt++;
        if (ext_tx_valid !== 1'b0) $display("FAIL tx_drained got=%b exp=0", ext_tx_valid);
        else pass_cnt++;
        ext_tx_ready = 1'b0;
    endtask

    task automatic test_tx_overflow();
        logic [DATA_W-1:0] w [5];
        for (int i = 0; i < 5; i++) w[i] = DATA_W'($urandom);
        ext_tx_ready = 1'b0;
        core_out_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            core_out_data = w[i];
`ifdef IO_ERR_FLAGS_EN
            if (i == 4) begin
                check_cnt++;
                if (err_overflow !== 1'b0) $display("FAIL ovf_before got=%b exp=0", err_overflow);
                else pass_cnt++;
            end
`endif
            tick();
            if (i == 2) begin
                check_cnt++;
                if (core_out_full !== 1'b0) $display("FAIL full_after3 got=%b exp=0", core_out_full);
                else pass_cnt++;
            end
            if (i >= 3) begin
                check_cnt++;
                if (core_out_full !== 1'b1) $display("FAIL full_after%0d got=%b exp=1", i + 1, core_out_full);
                else pass_cnt++;
            end
        end
        core_out_req = 1'b0;
`ifdef IO_ERR_FLAGS_EN
        check_cnt++;
        if (err_overflow !== 1'b1) $display("FAIL ovf_set got=%b exp=1", err_overflow);
        else pass_cnt++;
`endif
        ext_tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_cnt++;
            if (ext_tx_valid !== 1'b1 || ext_tx_data !== w[i])
                $display("FAIL drain%0d got=%b/%h exp=1/%h", i, ext_tx_valid, ext_tx_data, w[i]);
            else pass_cnt++;
            tick();
        end
        check_cnt++;
        if (ext_tx_valid !== 1'b0) $display("FAIL drain_empty got=%b exp=0", ext_tx_valid);
        else pass_cnt++;
        ext_tx_ready = 1'b0;
    endtask

    task automatic test_in_ready();
        ext_rx_valid = 1'b1;
        ext_rx_data  = 16'h00A5;
        tick();
        ext_rx_valid = 1'b0;
        core_in_req  = 1'b1;
        tick();
        check_cnt++;
        if (core_in_ack !== 1'b1 || core_in_data !== 16'h00A5)
            $display("FAIL in_ready got=%b/%h exp=1/00a5", core_in_ack, core_in_data);
        else pass_cnt++;
        core_in_req = 1'b0;
        tick();
        check_cnt++;
        if (core_in_ack !== 1'b0 || core_in_data !== 16'h00A5)
            $display("FAIL in_ready_hold got=%b/%h exp=0/00a5", core_in_ack, core_in_data);
        else pass_cnt++;
    endtask

    task automatic test_in_wait();
`ifdef IO_ERR_FLAGS_EN
        check_cnt++;
        if (err_underflow !== 1'b0) $display("FAIL unf_before got=%b exp=0", err_underflow);
        else pass_cnt++;
`endif
        core_in_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_cnt++;
            if (core_in_ack !== 1'b0) $display("FAIL wait_noack%0d got=%b exp=0", i, core_in_ack);
            else pass_cnt++;
        end
`ifdef IO_ERR_FLAGS_EN
        check_cnt++;
        if (err_underflow !== 1'b1) $display("FAIL unf_set got=%b exp=1", err_underflow);
        else pass_cnt++;
`endif
        ext_rx_valid = 1'b1;
        ext_rx_data  = 16'h7777;
        tick();
        ext_rx_valid = 1'b0;
        check_cnt++;
        if (core_in_ack !== 1'b0) $display("FAIL wait_push_cycle got=%b exp=0", core_in_ack);
        else pass_cnt++;
        tick();
        check_cnt++;
        if (core_in_ack !== 1'b1 || core_in_data !== 16'h7777)
            $display("FAIL wait_ack got=%b/%h exp=1/7777", core_in_ack, core_in_data);
        else pass_cnt++;
        core_in_req = 1'b0;
        tick();
    endtask

    task automatic test_rx_wrap();
        logic [DATA_W-1:0] w [6];
        logic [DATA_W-1:0] x;
        logic [DATA_W-1:0] y;
        for (int i = 0; i < 6; i++) w[i] = DATA_W'($urandom);
        x = DATA_W'($urandom);
        y = DATA_W'($urandom);
        ext_rx_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ext_rx_data = w[i];
            tick();
        end
        ext_rx_valid = 1'b0;
        check_cnt++;
        if (ext_rx_ready !== 1'b0) $display("FAIL rx_full_ready got=%b exp=0", ext_rx_ready);
        else pass_cnt++;
        for (int i = 0; i < 6; i++) begin
            if (i == 2) begin
                ext_rx_valid = 1'b1;
                for (int k = 4; k < 6; k++) begin
                    ext_rx_data = w[k];
                    tick();
                end
                ext_rx_valid = 1'b0;
            end
            core_in_req = 1'b1;
            tick();
            check_cnt++;
            if (core_in_ack !== 1'b1 || core_in_data !== w[i])
                $display("FAIL rx_order%0d got=%b/%h exp=1/%h", i, core_in_ack, core_in_data, w[i]);
            else pass_cnt++;
            core_in_req = 1'b0;
            tick();
        end
        // One stored word, then push and pop in the same cycle
        ext_rx_valid = 1'b1;
        ext_rx_data  = x;
        tick();
        ext_rx_data  = y;
        core_in_req  = 1'b1;
        tick();
        ext_rx_valid = 1'b0;
        check_cnt++;
        if (core_in_ack !== 1'b1 || core_in_data !== x)
            $display("FAIL simul_pop got=%b/%h exp=1/%h", core_in_ack, core_in_data, x);
        else pass_cnt++;
        core_in_req = 1'b0;
        tick();
        core_in_req = 1'b1;
        tick();
        check_cnt++;
        if (core_in_ack !== 1'b1 || core_in_data !== y)
            $display("FAIL simul_second got=%b/%h exp=1/%h", core_in_ack, core_in_data, y);
        else pass_cnt++;
        core_in_req = 1'b0;
        tick();
        core_in_req = 1'b1;
        tick();
        check_cnt++;
        if (core_in_ack !== 1'b0) $display("FAIL simul_now_empty got=%b exp=0", core_in_ack);
        else pass_cnt++;
        core_in_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        ext_tx_ready  = 1'b0;
        core_out_req  = 1'b1;
        core_out_data = 16'hCAFE;
        tick();
        core_out_data = 16'hF00D;
        tick();
        core_out_req  = 1'b0;
        core_in_req   = 1'b1;
        tick();
        check_cnt++;
        if (ext_tx_valid !== 1'b1 || core_in_ack !== 1'b0)
            $display("FAIL pre_reset got=%b/%b exp=1/0", ext_tx_valid, core_in_ack);
        else pass_cnt++;
        #2;
        reset_n = 1'b0;
        idle_inputs();
        model_reset();
        #1;
        check_cnt++;
        if (core_out_full !== 1'b0 || ext_tx_valid !== 1'b0 || ext_rx_ready !== 1'b1 ||
            core_in_ack !== 1'b0 || core_in_data !== 16'h0000)
            $display("FAIL mid_reset got full=%b txv=%b rxr=%b ack=%b data=%h exp 0/0/1/0/0000",
                     core_out_full, ext_tx_valid, ext_rx_ready, core_in_ack, core_in_data);
        else pass_cnt++;
`ifdef IO_ERR_FLAGS_EN
        check_cnt++;
        if ({err_overflow, err_underflow} !== 2'b00)
            $display("FAIL mid_reset_flags got=%b%b exp=00", err_overflow, err_underflow);
        else pass_cnt++;
`endif
        @(negedge clock);
        reset_n      = 1'b1;
        ext_rx_valid = 1'b1;
        ext_rx_data  = 16'h5A5A;
        tick();
        ext_rx_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_cnt++;
            if (core_in_ack !== 1'b0 || ext_tx_valid !== 1'b0)
                $display("FAIL post_reset%0d got ack=%b txv=%b exp 0/0", i, core_in_ack, ext_tx_valid);
            else pass_cnt++;
            tick();
        end
        core_in_req = 1'b1;
        tick();
        check_cnt++;
        if (core_in_ack !== 1'b1 || core_in_data !== 16'h5A5A)
            $display("FAIL post_reset_in got=%b/%h exp=1/5a5a", core_in_ack, core_in_data);
        else pass_cnt++;
        core_in_req = 1'b0;
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            check_cnt++;
            if (ext_tx_valid !== (tx_q.size() != 0))
                $display("FAIL rnd_tx_valid cyc=%0d got=%b exp=%0d", c, ext_tx_valid, tx_q.size() != 0);
            else pass_cnt++;
            if (tx_q.size() != 0) begin
                check_cnt++;
                if (ext_tx_data !== tx_q[0])
                    $display("FAIL rnd_tx_data cyc=%0d got=%h exp=%h", c, ext_tx_data, tx_q[0]);
                else pass_cnt++;
            end
            check_cnt++;
            if (core_out_full !== (tx_q.size() == DEPTH))
                $display("FAIL rnd_full cyc=%0d got=%b exp=%0d", c, core_out_full, tx_q.size() == DEPTH);
            else pass_cnt++;
            check_cnt++;
            if (ext_rx_ready !== (rx_q.size() != DEPTH))
                $display("FAIL rnd_rx_ready cyc=%0d got=%b exp=%0d", c, ext_rx_ready, rx_q.size() != DEPTH);
            else pass_cnt++;
            check_cnt++;
            if (core_in_ack !== m_ack || core_in_data !== m_in_data)
                $display("FAIL rnd_in cyc=%0d got=%b/%h exp=%b/%h", c, core_in_ack, core_in_data, m_ack, m_in_data);
            else pass_cnt++;
`ifdef IO_ERR_FLAGS_EN
            check_cnt++;
            if (err_overflow !== m_ovf || err_underflow !== m_unf)
                $display("FAIL rnd_flags cyc=%0d got=%b%b exp=%b%b", c, err_overflow, err_underflow, m_ovf, m_unf);
            else pass_cnt++;
`endif
            // Alternate phases bias toward filling and draining each FIFO
            core_out_req  = ($urandom_range(0, 2) != 0);
            core_out_data = DATA_W'($urandom);
            ext_tx_ready  = (c % 200 < 100) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            ext_rx_valid  = (c % 150 < 75) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            ext_rx_data   = DATA_W'($urandom);
            core_in_req   = ($urandom_range(0, 1) == 1);
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_tx_basic();
        test_tx_overflow();
        test_in_ready();
        test_in_wait();
        test_rx_wrap();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
